modn_updown_counter: RTL and testbench

MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

---
 rtl/counter_pkg.sv | 9 +
 rtl/modn_step.sv | 31 +++
 rtl/modn_updown_counter.sv | 63 ++++++
 tb/tb_modn_updown_counter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared terminal-behaviour modes for the modulo-N counter
package counter_pkg;
  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2,
    RSVD    = 2'd3
  } mode_e;
endpackage

// File: rtl/modn_step.sv
// modn_step: combinational next-count arithmetic with overflow/underflow detection
module modn_step
  import counter_pkg::*;
#(
  parameter int MODULUS = 12,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] step,
  input  logic             up_down,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf,
  output logic             unf
);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX = MOD - 1'b1;
  logic [WIDTH:0] c, s, sum, diff;
  logic clamp;
  always_comb begin
    c     = {1'b0, cur};
    s     = {1'b0, step} > MAX ? MAX : {1'b0, step};
    sum   = c + s;
    diff  = c - s;
    ovf   = up_down && sum >= MOD;
    unf   = !up_down && c < s;
    clamp = mode == SAT || mode == ONESHOT;
    nxt   = WIDTH'(up_down ? (ovf ? (clamp ? MAX : sum - MOD) : sum)
                           : (unf ? (clamp ? '0 : diff + MOD) : diff));
  end
endmodule

// File: rtl/modn_updown_counter.sv
// modn_updown_counter: loadable modulo-N up/down counter with wrap, saturate and one-shot modes
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = 12,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             carry,
  output logic             borrow,
  output logic             halted,
  output logic             load_err
);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
  logic [WIDTH-1:0] nxt;
  logic ovf, unf, os_lock, wrap, cnt, bad;
  modn_step #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_step (
    .cur(dout), .step(step), .up_down(up_down), .mode(mode),
    .nxt(nxt), .ovf(ovf), .unf(unf)
  );
  always_comb begin
    wrap = !(mode == SAT || mode == ONESHOT);
    cnt  = en && !os_lock;
    bad  = {1'b0, din} >= MOD;
    tc   = up_down ? dout == WIDTH'(MODULUS - 1) : dout == '0;
  end
  // os_lock holds a one-shot halt independent of later mode changes until load/rst
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      halted   <= 1'b0;
      load_err <= 1'b0;
      os_lock  <= 1'b0;
    end else begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        dout     <= bad ? '0 : din;
        load_err <= bad;
        halted   <= 1'b0;
        os_lock  <= 1'b0;
      end else if (cnt) begin
        dout    <= nxt;
        carry   <= wrap && ovf;
        borrow  <= wrap && unf;
        halted  <= (!wrap && (ovf || unf)) || (halted && nxt == dout);
        os_lock <= mode == ONESHOT && (ovf || unf);
      end
    end
  end
endmodule

// File: tb/tb_modn_updown_counter.sv
// tb_modn_updown_counter: directed-vector self-checking bench for MODULUS=12
module tb_modn_updown_counter;
  logic clk = 1'b0;
  logic rst, en, load, up_down, tc, carry, borrow, halted, load_err;
  logic [3:0] din, step, dout;
  logic [1:0] mode;
  int vectors = 0;
  int errs = 0;

  modn_updown_counter #(.MODULUS(12), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .up_down(up_down),
    .step(step), .mode(mode), .dout(dout), .tc(tc), .carry(carry),
    .borrow(borrow), .halted(halted), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] d);
    load = 1'b1;
    din = d;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; load = 1'b1; din = 4'd7; up_down = 1'b0; step = 4'd1; mode = 2'd0;
    tick();
    rst = 1'b0; en = 1'b0; load = 1'b0;
    vectors++; if (dout !== 4'd0) begin errs++; $display("FAIL reset_dout got %0d want 0", dout); end
    vectors++; if ({carry, borrow, halted, load_err} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b want 0000", {carry, borrow, halted, load_err}); end
    vectors++; if (tc !== 1'b1) begin errs++; $display("FAIL reset_tc_down got %b want 1", tc); end
    up_down = 1'b1; #1;
    vectors++; if (tc !== 1'b0) begin errs++; $display("FAIL reset_tc_up got %b want 0", tc); end
  endtask

  task automatic test_wrap_up;
    mode = 2'd0; do_load(4'd10);
    up_down = 1'b1; step = 4'd3; en = 1'b1;
    tick(); en = 1'b0;
    vectors++; if (dout !== 4'd1) begin errs++; $display("FAIL wrap_up_dout got %0d want 1", dout); end
    vectors++; if (carry !== 1'b1) begin errs++; $display("FAIL wrap_up_carry got %b want 1", carry); end
    tick();
    vectors++; if (carry !== 1'b0 || dout !== 4'd1) begin errs++; $display("FAIL wrap_up_pulse got carry=%b dout=%0d want 0/1", carry, dout); end
  endtask

  task automatic test_wrap_down;
    mode = 2'd0; do_load(4'd1);
    up_down = 1'b0; step = 4'd2; en = 1'b1;
    tick(); en = 1'b0;
    vectors++; if (dout !== 4'd11) begin errs++; $display("FAIL wrap_dn_dout got %0d want 11", dout); end
    vectors++; if (borrow !== 1'b1 || carry !== 1'b0) begin errs++; $display("FAIL wrap_dn_borrow got b=%b c=%b want 1/0", borrow, carry); end
    vectors++; if (tc !== 1'b0) begin errs++; $display("FAIL wrap_dn_tc got %b want 0", tc); end
    tick();
    vectors++; if (borrow !== 1'b0) begin errs++; $display("FAIL wrap_dn_pulse got %b want 0", borrow); end
  endtask

  task automatic test_step_clamp;
    mode = 2'd0; do_load(4'd4);
    up_down = 1'b1; step = 4'd15; en = 1'b1;
    tick(); en = 1'b0;
    vectors++; if (dout !== 4'd3 || carry !== 1'b1) begin errs++; $display("FAIL step_clamp got dout=%0d carry=%b want 3/1", dout, carry); end
  endtask

  task automatic test_sat;
    en = 1'b0; mode = 2'd1; do_load(4'd9);
    up_down = 1'b1; step = 4'd5; en = 1'b1;
    tick();
    vectors++; if (dout !== 4'd11 || halted !== 1'b1) begin errs++; $display("FAIL sat_up got dout=%0d halted=%b want 11/1", dout, halted); end
    vectors++; if (carry !== 1'b0) begin errs++; $display("FAIL sat_no_carry got %b want 0", carry); end
    step = 4'd0;
    tick();
    vectors++; if (dout !== 4'd11 || halted !== 1'b1) begin errs++; $display("FAIL sat_step0 got dout=%0d halted=%b want 11/1", dout, halted); end
    up_down = 1'b0; step = 4'd1;
    tick(); en = 1'b0;
    vectors++; if (dout !== 4'd10 || halted !== 1'b0) begin errs++; $display("FAIL sat_release got dout=%0d halted=%b want 10/0", dout, halted); end
  endtask

  task automatic test_oneshot;
    en = 1'b0; mode = 2'd2; do_load(4'd2);
    up_down = 1'b0; step = 4'd1; en = 1'b1;
    tick(); tick(); tick();
    vectors++; if (dout !== 4'd0 || halted !== 1'b1) begin errs++; $display("FAIL oneshot_halt got dout=%0d halted=%b want 0/1", dout, halted); end
    mode = 2'd0; up_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (dout !== 4'd0 || halted !== 1'b1 || carry !== 1'b0) begin errs++; $display("FAIL oneshot_hold%0d got dout=%0d halted=%b carry=%b want 0/1/0", i, dout, halted, carry); end
    end
    en = 1'b0; do_load(4'd7);
    vectors++; if (dout !== 4'd7 || halted !== 1'b0) begin errs++; $display("FAIL oneshot_reload got dout=%0d halted=%b want 7/0", dout, halted); end
    en = 1'b1;
    tick(); en = 1'b0;
    vectors++; if (dout !== 4'd8) begin errs++; $display("FAIL oneshot_resume got %0d want 8", dout); end
  endtask

  task automatic test_load_err;
    en = 1'b0; mode = 2'd0; do_load(4'd13);
    vectors++; if (dout !== 4'd0 || load_err !== 1'b1) begin errs++; $display("FAIL load_err got dout=%0d err=%b want 0/1", dout, load_err); end
    tick();
    vectors++; if (load_err !== 1'b0) begin errs++; $display("FAIL load_err_pulse got %b want 0", load_err); end
    do_load(4'd11);
    up_down = 1'b1; step = 4'd3; en = 1'b1; load = 1'b1; din = 4'd5;
    tick(); load = 1'b0; en = 1'b0;
    vectors++; if (dout !== 4'd5 || carry !== 1'b0 || load_err !== 1'b0) begin errs++; $display("FAIL load_en got dout=%0d carry=%b err=%b want 5/0/0", dout, carry, load_err); end
  endtask

  task automatic test_rst_mid;
    mode = 2'd0; do_load(4'd3);
    up_down = 1'b1; step = 4'd3; en = 1'b1;
    tick();
    vectors++; if (dout !== 4'd6) begin errs++; $display("FAIL rst_pre got %0d want 6", dout); end
    rst = 1'b1; load = 1'b1; din = 4'd9;
    tick(); rst = 1'b0; load = 1'b0; en = 1'b0;
    vectors++; if (dout !== 4'd0 || {carry, borrow, halted, load_err} !== 4'b0) begin errs++; $display("FAIL rst_mid got dout=%0d flags=%b want 0/0000", dout, {carry, borrow, halted, load_err}); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_step_clamp();
    test_sat();
    test_oneshot();
    test_load_err();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
